control_pipeline: RTL and testbench
===================================

// Module: control_pipeline
// PURPOSE
//  Decodes the ARM-subset instruction word from IF/ID and carries the control bundle through a
//  parametrised chain of pipeline registers (ID/EX onward). Also evaluates condition codes,
//  inserts bubbles on stall/flush, and can kill the slot after a taken branch.
//  Successor to the purely combinational control unit: same decode, now staged and hazard-aware.
// PARAMETERS
//  STAGES     3   pipeline registers after ID (1..6); stage 0 = ID/EX
//  KILL_SLOT  1   1: bubble the instruction following a taken branch; 0: delay slot executes
//  CNT_W      16  width of saturating bubble counter
// PORTS
//  clk           in   1              rising-edge clock
//  reset         in   1              asynchronous, active-high
//  ir            in   32             instruction word from IF/ID
//  flags         in   4              current {N,Z,C,V}
//  stall         in   1              hazard unit: hold ID, bubble into stage 0
//  flush         in   1              external squash of ID instruction
//  ctrl_q        out  STAGES*CTRL_W  packed stage bundles, stage 0 in LSBs
//  branch_taken  out  1              stage 0 holds valid branch (= stage0.b & stage0.valid)
//  bubble_cnt    out  CNT_W          count of bubbles inserted, saturating
// BEHAVIOUR
//  Bundle (CTRL_W=13, MSB->LSB): valid, se, li, rf, b, rw, bl, opcode[3:0], size[1:0].
//  Decode (combinational, ID), type=ir[27:25]:
//   - 000/001 data-proc: opcode=ir[24:21]; se=ir[20] (set flags); li=(type==001) immediate operand;
//     rf=1 except opcodes 1000..1011 (TST/TEQ/CMP/CMN) rf=0; rw=0; size=2'b10.
//   - 010/011 load/store: opcode = ir[23] ? 4'b0100 : 4'b0010; li=(type==010);
//     rw=ir[20] (1=load); rf=ir[20]; size = ir[22] ? 2'b00 : 2'b10; se=0.
//   - 101 branch: b=1; bl=ir[24]; rf=ir[24] (link to R14); opcode=4'b0100; size=2'b10.
//   - ir==32'h0 or any other type: all-zero bundle (NOP, valid=0).
//  Condition ir[31:28] evaluated against flags (EQ..AL per ARM; 1111 = never).
//   Fail -> whole bundle zeroed (valid=0).
//  Stage 0 load each cycle:
//   - bubble (all zeros) when stall | flush | (KILL_SLOT & branch_taken);
//   - else the decoded bundle.
//  Stages 1..STAGES-1 always shift (stage k <= stage k-1). Stall does not freeze downstream.
//  Simultaneous stall+flush -> one bubble; cnt increments by 1.
//  bubble_cnt: +1 per cycle stage 0 loads a forced bubble (not a decoded NOP/cond-fail);
//   holds at all-ones.
//  Latency: an instruction's bundle appears in stage k after k+1 clock edges.
//  Reset (any time, async): every stage, branch_taken and bubble_cnt = 0 immediately.
//   First post-reset edge loads stage 0 normally.
// STRUCTURE
//  Package control_pkg: CTRL_W, bundle field offsets, type codes (DP_REG, DP_IMM, LS_IMM,
//   LS_REG, BR), condition codes, and a function cond_pass(cond, flags).
//  Sub-module control_decode (pure combinational ir -> bundle). Stages are a generate loop here.
// TESTING
//  1 ir=E0825005 (ADD), flags=0 -> next edge stage0 = valid,rf=1,opcode=0100,size=10,se=0,li=0.
//  2 ir=E2533001 (SUBS #1) -> stage0 se=1,li=1,rf=1,opcode=0010;
//    after 2 more edges the same bundle is in stage 2.
//  3 ir=1AFFFFFD (BNE), Z=0 -> stage0 b=1, branch_taken=1;
//    KILL_SLOT=1: next stage0 = 0 and bubble_cnt=1. Repeat with Z=1 -> bundle 0, no taken.
//  4 ir=E5C15003 (STRB) -> rw=0,rf=0,size=00,opcode=0100,li=1.
//    ir=DB000001 (BLLE), Z=1 -> b=1,bl=1,rf=1.
//  5 Stall high 2 cycles mid-stream -> stage0 zero twice, older bundles keep advancing,
//    bubble_cnt +=2; stall+flush together -> +1.
//  6 Assert reset between edges with full pipe -> all outputs 0 without a clock edge;
//    CNT_W=2 with 5 bubbles -> bubble_cnt sticks at 3.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the staged control unit: bundle layout,
// instruction class codes, condition codes and the condition evaluator.
package control_pkg;

  localparam int CTRL_W    = 13;

  // Bit offsets of the bundle fields, MSB to LSB.
  localparam int VALID_BIT = 12;
  localparam int SE_BIT    = 11;
  localparam int LI_BIT    = 10;
  localparam int RF_BIT    = 9;
  localparam int B_BIT     = 8;
  localparam int RW_BIT    = 7;
  localparam int BL_BIT    = 6;
  localparam int OP_LSB    = 2;
  localparam int SIZE_LSB  = 0;

  typedef struct packed {
    logic       valid;
    logic       se;
    logic       li;
    logic       rf;
    logic       b;
    logic       rw;
    logic       bl;
    logic [3:0] opcode;
    logic [1:0] size;
  } ctrl_t;

  // Instruction class, taken from ir[27:25].
  typedef enum logic [2:0] {
    DP_REG = 3'b000,
    DP_IMM = 3'b001,
    LS_IMM = 3'b010,
    LS_REG = 3'b011,
    BR     = 3'b101
  } itype_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  // Evaluate an ARM condition field against {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic pass;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational decode of one instruction word into a control bundle.
// A failed condition, a zero word or an unsupported class yields all zeros.
module control_decode
  import control_pkg::*;
(
  input  logic [31:0]       ir,
  input  logic [3:0]        flags,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t      c;
  logic [2:0] cls;

  assign cls  = ir[27:25];
  assign ctrl = c;

  // Field extraction per instruction class, gated by the condition check.
  always_comb begin
    c = '0;
    if ((ir != 32'h0) && cond_pass(ir[31:28], flags)) begin
      case (cls)
        DP_REG, DP_IMM: begin
          c.valid  = 1'b1;
          c.opcode = ir[24:21];
          c.se     = ir[20];
          c.li     = (cls == DP_IMM);
          // TST/TEQ/CMP/CMN (1000..1011) only set flags, no register write.
          c.rf     = (ir[24:23] != 2'b10);
          c.size   = 2'b10;
        end
        LS_IMM, LS_REG: begin
          c.valid  = 1'b1;
          c.opcode = ir[23] ? 4'b0100 : 4'b0010;
          c.li     = (cls == LS_IMM);
          c.rw     = ir[20];
          c.rf     = ir[20];
          c.size   = ir[22] ? 2'b00 : 2'b10;
        end
        BR: begin
          c.valid  = 1'b1;
          c.b      = 1'b1;
          c.bl     = ir[24];
          c.rf     = ir[24];
          c.opcode = 4'b0100;
          c.size   = 2'b10;
        end
        default: c = '0;
      endcase
    end
  end

endmodule

// File: rtl/control_pipeline.sv
// Staged control unit: decodes in ID and shifts the bundle through STAGES
// registers. Stage 0 takes a bubble on stall, flush or the slot after a
// taken branch; a saturating counter records how many were forced.
module control_pipeline
  import control_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int KILL_SLOT = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              ir,
  input  logic [3:0]               flags,
  input  logic                     stall,
  input  logic                     flush,
  output logic [STAGES*CTRL_W-1:0] ctrl_q,
  output logic                     branch_taken,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam logic KILL_EN = (KILL_SLOT != 0);

  logic [CTRL_W-1:0] decoded;
  logic              force_bubble;

  control_decode u_decode (
    .ir    (ir),
    .flags (flags),
    .ctrl  (decoded)
  );

  assign force_bubble = stall | flush | (KILL_EN & branch_taken);

  for (genvar gi = 0; gi < STAGES; gi++) begin : stage_gen
    logic [CTRL_W-1:0] q;

    if (gi == 0) begin : g_head
      // ID/EX register: decoded bundle unless a bubble is forced.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (force_bubble) begin
          q <= '0;
        end else begin
          q <= decoded;
        end
      end
    end else begin : g_tail
      // Downstream stages shift every cycle, independent of stall.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else begin
          q <= stage_gen[gi-1].q;
        end
      end
    end

    assign ctrl_q[gi*CTRL_W +: CTRL_W] = q;
  end

  assign branch_taken = stage_gen[0].q[B_BIT] & stage_gen[0].q[VALID_BIT];

  // Count forced bubbles only; holds once all ones is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (force_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: a 3-stage kill-slot instance and a
// 1-stage delay-slot instance with a 2-bit counter share the same stimulus.
module tb_control_pipeline;
  import control_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [31:0]           ir;
  logic [3:0]            flags;
  logic                  stall;
  logic                  flush;
  logic [3*CTRL_W-1:0]   ctrl_q;
  logic                  branch_taken;
  logic [15:0]           bubble_cnt;
  logic [CTRL_W-1:0]     ctrl_q2;
  logic                  branch_taken2;
  logic [1:0]            bubble_cnt2;

  int errors = 0;
  int checks = 0;

  logic [CTRL_W-1:0] exp_q[$];
  logic [CTRL_W-1:0] exp_q2[$];
  logic [CTRL_W-1:0] hist[3];
  logic [CTRL_W-1:0] hist2;
  logic [15:0]       exp_cnt;
  logic [1:0]        exp_cnt2;

  always #5 clk = ~clk;

  control_pipeline #(.STAGES(3), .KILL_SLOT(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ir(ir), .flags(flags), .stall(stall), .flush(flush),
    .ctrl_q(ctrl_q), .branch_taken(branch_taken), .bubble_cnt(bubble_cnt)
  );

  control_pipeline #(.STAGES(1), .KILL_SLOT(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .ir(ir), .flags(flags), .stall(stall), .flush(flush),
    .ctrl_q(ctrl_q2), .branch_taken(branch_taken2), .bubble_cnt(bubble_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [CTRL_W-1:0] mk(input logic v, se, li, rf, b, rw, bl,
                                          input logic [3:0] op, input logic [1:0] sz);
    return {v, se, li, rf, b, rw, bl, op, sz};
  endfunction

  localparam logic [31:0] I_ADD  = 32'hE0825005;
  localparam logic [31:0] I_SUBS = 32'hE2533001;
  localparam logic [31:0] I_BNE  = 32'h1AFFFFFD;
  localparam logic [31:0] I_STRB = 32'hE5C15003;
  localparam logic [31:0] I_BLLE = 32'hDB000001;
  localparam logic [31:0] I_CMP  = 32'hE1530001;
  localparam logic [31:0] I_LDR  = 32'hE5912004;
  localparam logic [31:0] I_LDRR = 32'hE7912004;
  localparam logic [31:0] I_LDM  = 32'hE8BD0001;
  localparam logic [31:0] I_NV   = 32'hF0825005;
  localparam logic [31:0] I_GT   = 32'hC0825005;
  localparam logic [31:0] I_EQ   = 32'h00825005;

  logic [CTRL_W-1:0] b_add, b_subs, b_bne, b_strb, b_blle, b_cmp, b_ldr, b_ldrr;

  task automatic clear_model();
    exp_q.delete();
    exp_q2.delete();
    for (int k = 0; k < 3; k++) hist[k] = '0;
    hist2    = '0;
    exp_cnt  = '0;
    exp_cnt2 = '0;
  endtask

  // Drive one ID slot, record expectations, then check after the edge.
  task automatic step(input string name, input logic [31:0] i, input logic [3:0] f,
                      input logic st, input logic fl, input logic [CTRL_W-1:0] dec);
    logic              kill;
    logic [CTRL_W-1:0] e;
    logic [CTRL_W-1:0] e2;
    ir    = i;
    flags = f;
    stall = st;
    flush = fl;
    kill  = st | fl | (hist[0][VALID_BIT] & hist[0][B_BIT]);
    exp_q.push_back(kill ? '0 : dec);
    exp_q2.push_back((st | fl) ? '0 : dec);
    if (kill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    if ((st | fl) && exp_cnt2 != 2'b11) exp_cnt2 = exp_cnt2 + 2'd1;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0 || exp_q2.size() == 0) begin
      check({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e  = exp_q.pop_front();
      e2 = exp_q2.pop_front();
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e;
      hist2   = e2;
      check({name, "_s0"}, 32'(ctrl_q[CTRL_W-1:0]), 32'(hist[0]));
      check({name, "_s1"}, 32'(ctrl_q[2*CTRL_W-1:CTRL_W]), 32'(hist[1]));
      check({name, "_s2"}, 32'(ctrl_q[3*CTRL_W-1:2*CTRL_W]), 32'(hist[2]));
      check({name, "_bt"}, 32'(branch_taken), 32'(hist[0][VALID_BIT] & hist[0][B_BIT]));
      check({name, "_cnt"}, 32'(bubble_cnt), 32'(exp_cnt));
      check({name, "_d2_s0"}, 32'(ctrl_q2), 32'(hist2));
      check({name, "_d2_bt"}, 32'(branch_taken2), 32'(hist2[VALID_BIT] & hist2[B_BIT]));
      check({name, "_d2_cnt"}, 32'(bubble_cnt2), 32'(exp_cnt2));
    end
    $display("txn %-8s ir=%h fl=%b st=%b fx=%b s0=%h s1=%h s2=%h bt=%b cnt=%0d cnt2=%0d",
             name, i, f, st, fl, ctrl_q[CTRL_W-1:0], ctrl_q[2*CTRL_W-1:CTRL_W],
             ctrl_q[3*CTRL_W-1:2*CTRL_W], branch_taken, bubble_cnt, bubble_cnt2);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 32'(ctrl_q[3*CTRL_W-1:0] != '0), 32'd0);
    check({name, "_bt"}, 32'(branch_taken), 32'd0);
    check({name, "_cnt"}, 32'(bubble_cnt), 32'd0);
    check({name, "_d2_ctrl"}, 32'(ctrl_q2), 32'd0);
    check({name, "_d2_cnt"}, 32'(bubble_cnt2), 32'd0);
  endtask

  initial begin
    b_add  = mk(1, 0, 0, 1, 0, 0, 0, 4'b0100, 2'b10);
    b_subs = mk(1, 1, 1, 1, 0, 0, 0, 4'b0010, 2'b10);
    b_bne  = mk(1, 0, 0, 0, 1, 0, 0, 4'b0100, 2'b10);
    b_strb = mk(1, 0, 1, 0, 0, 0, 0, 4'b0100, 2'b00);
    b_blle = mk(1, 0, 0, 1, 1, 0, 1, 4'b0100, 2'b10);
    b_cmp  = mk(1, 1, 0, 0, 0, 0, 0, 4'b1010, 2'b10);
    b_ldr  = mk(1, 0, 1, 1, 0, 1, 0, 4'b0100, 2'b10);
    b_ldrr = mk(1, 0, 0, 1, 0, 1, 0, 4'b0100, 2'b10);

    reset = 1'b1;
    ir    = I_ADD;
    flags = 4'b0000;
    stall = 1'b0;
    flush = 1'b0;
    clear_model();
    #2;
    check_all_zero("rst0");
    @(posedge clk);
    #1;
    check_all_zero("rst_edge");
    reset = 1'b0;

    // Basic decode and latency
    step("add",  I_ADD,  4'b0000, 0, 0, b_add);
    step("subs", I_SUBS, 4'b0000, 0, 0, b_subs);
    step("nop0", 32'h0,  4'b0000, 0, 0, '0);
    step("nop1", 32'h0,  4'b0000, 0, 0, '0);
    check("subs_in_s2", 32'(ctrl_q[3*CTRL_W-1:2*CTRL_W]), 32'(b_subs));

    // Taken branch kills the following slot; untaken one does not
    step("bne_t",  I_BNE, 4'b0000, 0, 0, b_bne);
    step("slot",   I_ADD, 4'b0000, 0, 0, b_add);
    step("bne_nt", I_BNE, 4'b0100, 0, 0, '0);
    step("add2",   I_ADD, 4'b0000, 0, 0, b_add);

    // Load/store, link branch and misc classes
    step("strb",  I_STRB, 4'b0000, 0, 0, b_strb);
    step("blle",  I_BLLE, 4'b0100, 0, 0, b_blle);
    step("slot2", I_ADD,  4'b0000, 0, 0, b_add);
    step("cmp",   I_CMP,  4'b0000, 0, 0, b_cmp);
    step("ldr",   I_LDR,  4'b0000, 0, 0, b_ldr);
    step("ldrr",  I_LDRR, 4'b0000, 0, 0, b_ldrr);
    step("ldm",   I_LDM,  4'b0000, 0, 0, '0);
    step("nv",    I_NV,   4'b0000, 0, 0, '0);
    step("gt_f",  I_GT,   4'b1000, 0, 0, '0);
    step("gt_p",  I_GT,   4'b0000, 0, 0, b_add);
    step("eq_f",  I_EQ,   4'b0000, 0, 0, '0);

    // Stall, flush and both together
    step("pre",   I_ADD,  4'b0000, 0, 0, b_add);
    step("stl0",  I_SUBS, 4'b0000, 1, 0, b_subs);
    step("stl1",  I_SUBS, 4'b0000, 1, 0, b_subs);
    step("post",  I_SUBS, 4'b0000, 0, 0, b_subs);
    step("both",  I_CMP,  4'b0000, 1, 1, b_cmp);
    step("flsh",  I_LDR,  4'b0000, 0, 1, b_ldr);
    step("after", I_LDR,  4'b0000, 0, 0, b_ldr);

    // Asynchronous reset between edges with a full pipe
    step("fill0", I_ADD,  4'b0000, 0, 0, b_add);
    step("fill1", I_BNE,  4'b0000, 0, 0, b_bne);
    step("fill2", I_LDR,  4'b0000, 0, 0, b_ldr);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("arst");
    clear_model();
    #1;
    reset = 1'b0;
    step("first", I_SUBS, 4'b0000, 0, 0, b_subs);

    // Five forced bubbles: the 2-bit counter sticks at 3
    for (int k = 0; k < 5; k++) step("sat", I_ADD, 4'b0000, 1, 0, b_add);
    check("sat_cnt2", 32'(bubble_cnt2), 32'd3);
    check("sat_cnt16", 32'(bubble_cnt), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
